// File: rtl/multi_pulse_timer.sv
// Multi-channel pulse/timeout generator: each channel counts up to its own
// runtime-loadable terminal count and emits a one-cycle registered pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | channel stopped, cnt held at 0, waiting for start
// ST_RUN  | channel counting toward N; fires on cnt >= N when enabled
module multi_pulse_timer #(
   parameter int NCH       = 4,
   parameter int CBITS     = 10,
   parameter int DEFAULT_N = 750,
   parameter int LBITS     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   start,
   input  logic [NCH-1:0]   stop,
   input  logic [NCH-1:0]   en,
   input  logic [NCH-1:0]   mode,
   input  logic             load,
   input  logic [LBITS-1:0] load_ch,
   input  logic [CBITS-1:0] load_val,
   output logic [NCH-1:0]   sig,
   output logic [NCH-1:0]   busy,
   output logic             any_sig
);

   localparam logic [0:0]       ST_IDLE = 1'b0;
   localparam logic [0:0]       ST_RUN  = 1'b1;
   localparam logic [CBITS-1:0] N_RST   = CBITS'(DEFAULT_N);

   logic [0:0]       r_state [NCH];
   logic [CBITS-1:0] r_cnt   [NCH];
   logic [CBITS-1:0] r_n     [NCH];
   logic [NCH-1:0]   r_sig;
   logic [NCH-1:0]   w_load_hit;

   // Out-of-range channel indices simply match no channel.
   always_comb begin
      w_load_hit = '0;
      for (int i = 0; i < NCH; i++) begin
         w_load_hit[i] = load && (int'(load_ch) == i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sig <= '0;
         for (int i = 0; i < NCH; i++) begin
            r_state[i] <= ST_IDLE;
            r_cnt[i]   <= '0;
            r_n[i]     <= N_RST;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            r_sig[i] <= 1'b0;
            // The compare below still sees the old r_n in the load cycle.
            if (w_load_hit[i]) begin
               r_n[i] <= load_val;
            end
            case (r_state[i])
               ST_IDLE: begin
                  r_cnt[i] <= '0;
                  if (start[i] && !stop[i]) begin
                     r_state[i] <= ST_RUN;
                  end
               end
               default: begin
                  if (stop[i]) begin
                     r_state[i] <= ST_IDLE;
                     r_cnt[i]   <= '0;
                  end else if (start[i]) begin
                     r_cnt[i] <= '0;
                  end else if (en[i]) begin
                     if (r_cnt[i] >= r_n[i]) begin
                        r_sig[i] <= 1'b1;
                        r_cnt[i] <= '0;
                        if (mode[i]) begin
                           r_state[i] <= ST_IDLE;
                        end
                     end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < NCH; i++) begin
         busy[i] = (r_state[i] == ST_RUN);
      end
   end

   assign sig     = r_sig;
   assign any_sig = |r_sig;

endmodule

// File: tb/tb_multi_pulse_timer.sv
// Directed bench for multi_pulse_timer: pulse timing, one-shot, pause,
// retrigger, runtime loads, start/stop collisions and reset recovery.
module tb_multi_pulse_timer;

   localparam int NCH   = 4;
   localparam int CBITS = 10;
   localparam int LBITS = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [NCH-1:0]   start, stop, en, mode;
   logic             load;
   logic [LBITS-1:0] load_ch;
   logic [CBITS-1:0] load_val;
   logic [NCH-1:0]   sig, busy;
   logic             any_sig;

   int checks   = 0;
   int failures = 0;

   multi_pulse_timer #(.NCH(NCH), .CBITS(CBITS), .DEFAULT_N(750), .LBITS(LBITS)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .mode(mode),
      .load(load), .load_ch(load_ch), .load_val(load_val),
      .sig(sig), .busy(busy), .any_sig(any_sig)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int ch, input int val);
      load = 1'b1; load_ch = LBITS'(ch); load_val = CBITS'(val);
      tick();
      load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(); tick();
      checks++;
      if (sig !== '0 || busy !== '0 || any_sig !== 1'b0) begin
         failures++;
         $display("FAIL reset: sig=%b busy=%b any=%b required 0", sig, busy, any_sig);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_periodic();
      do_load(0, 3);
      mode[0] = 1'b0; en[0] = 1'b1; start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         checks++;
         if (sig[0] !== (e % 4 == 0) || any_sig !== (e % 4 == 0) || busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL periodic e=%0d: sig0=%b any=%b busy0=%b required sig=%b busy=1",
                     e, sig[0], any_sig, busy[0], (e % 4 == 0));
         end
      end
      stop[0] = 1'b1;
      tick();
      stop[0] = 1'b0;
      checks++;
      if (busy[0] !== 1'b0) begin
         failures++;
         $display("FAIL periodic_stop: busy0=%b required 0", busy[0]);
      end
   endtask

   task automatic test_one_shot();
      do_load(1, 5);
      mode[1] = 1'b1; en[1] = 1'b1; start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      for (int e = 1; e <= 56; e++) begin
         tick();
         checks++;
         if (sig[1] !== (e == 6) || busy[1] !== (e < 6)) begin
            failures++;
            $display("FAIL one_shot e=%0d: sig1=%b busy1=%b required sig=%b busy=%b",
                     e, sig[1], busy[1], (e == 6), (e < 6));
         end
      end
      mode[1] = 1'b0; en[1] = 1'b0;
   endtask

   task automatic test_pause_retrigger();
      logic exp_s;
      do_load(2, 4);
      mode[2] = 1'b0; en[2] = 1'b1; start[2] = 1'b1;
      tick();
      start[2] = 1'b0;
      for (int e = 1; e <= 30; e++) begin
         en[2]    = !(e == 7 || e == 8 || e == 9);
         start[2] = (e == 22);
         tick();
         exp_s = (e == 5 || e == 13 || e == 18 || e == 27);
         checks++;
         if (sig[2] !== exp_s) begin
            failures++;
            $display("FAIL pause_retrigger e=%0d: sig2=%b required %b", e, sig[2], exp_s);
         end
      end
      start[2] = 1'b0; stop[2] = 1'b1;
      tick();
      stop[2] = 1'b0; en[2] = 1'b0;
   endtask

   task automatic test_load_and_collision();
      logic exp_s;
      do_load(3, 20);
      mode[3] = 1'b0; en[3] = 1'b1; start[3] = 1'b1;
      tick();
      start[3] = 1'b0;
      for (int e = 1; e <= 25; e++) begin
         load = (e == 10 || e == 18);
         load_ch  = (e == 10) ? LBITS'(3) : LBITS'(4);
         load_val = (e == 10) ? CBITS'(2) : CBITS'(0);
         tick();
         load = 1'b0;
         exp_s = (e == 11 || e == 14 || e == 17 || e == 20 || e == 23);
         checks++;
         if (sig[3] !== exp_s) begin
            failures++;
            $display("FAIL load_lower e=%0d: sig3=%b required %b", e, sig[3], exp_s);
         end
      end
      // Channel 0 must still carry N=3 after the out-of-range load.
      en[0] = 1'b1; start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick();
         checks++;
         if (sig[0] !== (e == 4)) begin
            failures++;
            $display("FAIL load_out_of_range e=%0d: sig0=%b required %b", e, sig[0], (e == 4));
         end
      end
      start[0] = 1'b1; stop[0] = 1'b1;
      tick();
      start[0] = 1'b0; stop[0] = 1'b0;
      checks++;
      if (busy[0] !== 1'b0) begin
         failures++;
         $display("FAIL start_stop_run: busy0=%b required 0", busy[0]);
      end
      stop[3] = 1'b1;
      tick();
      start[3] = 1'b1;
      tick();
      start[3] = 1'b0; stop[3] = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         checks++;
         if (busy[3] !== 1'b0 || sig[3] !== 1'b0 || sig[0] !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_idle e=%0d: busy3=%b sig3=%b sig0=%b required 0",
                     e, busy[3], sig[3], sig[0]);
         end
      end
      en[3] = 1'b0;
   endtask

   task automatic test_zero_and_reset();
      do_load(0, 0);
      mode[0] = 1'b0; en[0] = 1'b1; start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         checks++;
         if (sig[0] !== 1'b1) begin
            failures++;
            $display("FAIL zero_periodic e=%0d: sig0=%b required 1", e, sig[0]);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if (sig !== '0 || busy !== '0 || any_sig !== 1'b0) begin
         failures++;
         $display("FAIL mid_run_reset: sig=%b busy=%b any=%b required 0", sig, busy, any_sig);
      end
      rst = 1'b1; start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      for (int e = 1; e <= 752; e++) begin
         tick();
         checks++;
         if (sig[0] !== (e == 751) || busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL default_n e=%0d: sig0=%b busy0=%b required sig=%b busy=1",
                     e, sig[0], busy[0], (e == 751));
         end
      end
   endtask

   initial begin
      rst = 1'b0; start = '0; stop = '0; en = '0; mode = '0;
      load = 1'b0; load_ch = '0; load_val = '0;
      test_reset();
      test_periodic();
      test_one_shot();
      test_pause_retrigger();
      test_load_and_collision();
      test_zero_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
